// File: rtl/cache_fill_ctrl.sv
// ============================================================================
// Module   : cache_fill_ctrl
// Purpose  : Miss-fill controller shared by the I-cache and D-cache over one
//            pipelined memory read port. D-cache misses win arbitration. The
//            block base address is latched, one word read is issued per cycle,
//            and returned words are counted on memory_data_valid. Each returned
//            word is written into the owner's data array. The owner's tag is
//            written together with the last word.
// Ports    : clk, rst_n (async, active-low)
//            imiss_detected/imiss_address, dmiss_detected/dmiss_address
//            memory_data_valid          - one returned word this cycle
//            fsm_busy_i / fsm_busy_d    - per-side stall
//            memory_read_en/address     - read request
//            write_data_array, data_word_offset - data-array word write
//            write_tag_array_i/_d       - tag write pulses
//            crit_word_valid            - only with the macro below
// Options  : `define CACHE_FILL_CRITICAL_WORD_FIRST_EN makes a fill start at
//            the missing word and wrap. It also adds crit_word_valid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_ctrl #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int WORD_BYTES      = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               imiss_detected,
  input  logic [ADDR_W-1:0]                  imiss_address,
  input  logic                               dmiss_detected,
  input  logic [ADDR_W-1:0]                  dmiss_address,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy_i,
  output logic                               fsm_busy_d,
  output logic                               memory_read_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_offset,
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  output logic                               crit_word_valid,
`endif
  output logic                               write_tag_array_i,
  output logic                               write_tag_array_d
);

  localparam int WIDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int BOFF_W = $clog2(WORD_BYTES);
  localparam int OFF_W  = WIDX_W + BOFF_W;
  localparam int BASE_W = ADDR_W - OFF_W;

  localparam logic [WIDX_W:0] BLOCK_WORDS = WORDS_PER_BLOCK[WIDX_W:0];
  localparam logic [WIDX_W:0] LAST_WORD   = BLOCK_WORDS - 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                owner_d;     // 1: fill belongs to the D-cache
  logic [BASE_W-1:0]   base;
  logic [WIDX_W:0]     req_cnt;
  logic [WIDX_W:0]     rsp_cnt;
  logic [WIDX_W-1:0]   req_word;
  logic [WIDX_W-1:0]   rsp_word;
  logic                last_rsp;

  // The byte-offset bits never reach the memory port. Without critical-word
  // ordering, the word-index bits of the miss address are also unused.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, imiss_address[OFF_W-1:0],
                              dmiss_address[OFF_W-1:0]};

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [WIDX_W-1:0] crit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crit <= '0;
    end else if (state == IDLE) begin
      if (dmiss_detected) begin
        crit <= dmiss_address[OFF_W-1:BOFF_W];
      end else if (imiss_detected) begin
        crit <= imiss_address[OFF_W-1:BOFF_W];
      end
    end
  end

  // The word index wraps naturally in WIDX_W bits.
  assign req_word = crit + req_cnt[WIDX_W-1:0];
  assign rsp_word = crit + rsp_cnt[WIDX_W-1:0];
`else
  assign req_word = req_cnt[WIDX_W-1:0];
  assign rsp_word = rsp_cnt[WIDX_W-1:0];
`endif

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner_d <= 1'b1;
      base    <= '0;
      req_cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          req_cnt <= '0;
          rsp_cnt <= '0;
          if (dmiss_detected) begin
            base    <= dmiss_address[ADDR_W-1:OFF_W];
            owner_d <= 1'b1;
          end else if (imiss_detected) begin
            base    <= imiss_address[ADDR_W-1:OFF_W];
            owner_d <= 1'b0;
          end
        end
        FILL: begin
          if (memory_read_en) begin
            req_cnt <= req_cnt + 1'b1;
          end
          if (write_data_array) begin
            rsp_cnt <= rsp_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and outputs
  always_comb begin
    state_nxt         = state;
    memory_read_en    = 1'b0;
    memory_address    = '0;
    write_data_array  = 1'b0;
    data_word_offset  = '0;
    write_tag_array_i = 1'b0;
    write_tag_array_d = 1'b0;
    last_rsp          = 1'b0;

    case (state)
      IDLE: begin
        if (dmiss_detected || imiss_detected) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        // Request and response sides run independently. Responses may
        // overlap the tail of the request burst.
        if (req_cnt < BLOCK_WORDS) begin
          memory_read_en = 1'b1;
          memory_address = ADDR_W'({base, req_word}) << BOFF_W;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_word_offset = rsp_word;
          last_rsp         = (rsp_cnt == LAST_WORD);
        end
        if (last_rsp) begin
          write_tag_array_d = owner_d;
          write_tag_array_i = !owner_d;
          state_nxt         = DONE;
        end
      end
      DONE: begin
        // New misses are ignored here so the re-lookup sees the new tag.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign crit_word_valid = write_data_array && (rsp_cnt == '0);
`endif

  // Each stall is combinational on the miss input, so a stall starts in the
  // same cycle as the miss.
  assign fsm_busy_d = dmiss_detected || ((state != IDLE) && owner_d);
  assign fsm_busy_i = imiss_detected || ((state != IDLE) && !owner_d);

endmodule

`default_nettype wire
